// File: rtl/alu_issue_ctrl.sv
// Issue/retire controller for the ALU_barrelShifter datapath: latches one
// instruction, checks its ARM condition against NZCV, and retires F/NZCV.
module alu_issue_ctrl #(
    parameter logic [3:0] RESET_NZCV = 4'b0000,
    parameter int         CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_cond,
    input  logic [3:0]       in_alu_op,
    input  logic             in_s,
    input  logic [3:0]       in_shft_op,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_shift_data,
    input  logic [31:0]      in_shift_num,
    input  logic [3:0]       in_rd,
    output logic [31:0]      A,
    output logic [31:0]      Shift_Data,
    output logic [31:0]      Shift_Num,
    output logic [3:0]       SHFT_OP,
    output logic [3:0]       ALU_OP,
    output logic             CF,
    output logic             VF,
    input  logic [31:0]      F,
    input  logic [3:0]       NZCV,
    output logic             wb_valid,
    output logic             wb_we,
    output logic [3:0]       wb_addr,
    output logic [31:0]      wb_data,
    output logic [3:0]       nzcv_q,
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] skip_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // ARM condition evaluation against flags {N,Z,C,V}; 1111 never passes.
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        logic r;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cond)
            4'b0000: r = z;
            4'b0001: r = ~z;
            4'b0010: r = c;
            4'b0011: r = ~c;
            4'b0100: r = n;
            4'b0101: r = ~n;
            4'b0110: r = v;
            4'b0111: r = ~v;
            4'b1000: r = c & ~z;
            4'b1001: r = ~c | z;
            4'b1010: r = (n == v);
            4'b1011: r = (n != v);
            4'b1100: r = ~z & (n == v);
            4'b1101: r = z | (n != v);
            4'b1110: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // TST/TEQ/CMP/CMN: flags only, never a register write.
    function automatic logic is_compare(input logic [3:0] op);
        return (op[3:2] == 2'b10);
    endfunction

    state_t state_r, next_state_s;

    logic [3:0]       cond_r, alu_op_r, shft_op_r, rd_r;
    logic             s_r;
    logic [31:0]      a_r, shift_data_r, shift_num_r;
    logic             in_ready_r, wb_valid_r, wb_we_r;
    logic [3:0]       wb_addr_r, nzcv_r;
    logic [31:0]      wb_data_r;
    logic [CNT_W-1:0] exec_cnt_r, skip_cnt_r;

    logic             accept_s, cond_pass_s, retire_s;
    logic             in_ready_s, wb_valid_s;

    assign accept_s    = (state_r == ST_IDLE) & in_valid;
    assign retire_s    = (state_r == ST_EXEC);
    assign cond_pass_s = cond_eval(cond_r, nzcv_r);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    next_state_s = ST_EXEC;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_EXEC: next_state_s = ST_WB;
            ST_WB:   next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Handshake outputs are decoded from the next state so they can be registered.
    always_comb begin
        in_ready_s = 1'b0;
        wb_valid_s = 1'b0;
        case (next_state_s)
            ST_IDLE: in_ready_s = 1'b1;
            ST_WB:   wb_valid_s = 1'b1;
            default: begin
                in_ready_s = 1'b0;
                wb_valid_s = 1'b0;
            end
        endcase
    end

    // Registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_r <= 1'b1;
            wb_valid_r <= 1'b0;
        end else begin
            in_ready_r <= in_ready_s;
            wb_valid_r <= wb_valid_s;
        end
    end

    // Operand latch; values persist while idle so the datapath stays stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            cond_r       <= 4'd0;
            alu_op_r     <= 4'd0;
            shft_op_r    <= 4'd0;
            rd_r         <= 4'd0;
            s_r          <= 1'b0;
            a_r          <= 32'd0;
            shift_data_r <= 32'd0;
            shift_num_r  <= 32'd0;
        end else if (accept_s) begin
            cond_r       <= in_cond;
            alu_op_r     <= in_alu_op;
            shft_op_r    <= in_shft_op;
            rd_r         <= in_rd;
            s_r          <= in_s;
            a_r          <= in_a;
            shift_data_r <= in_shift_data;
            shift_num_r  <= in_shift_num;
        end
    end

    // Retire: capture result, qualify write-back, update flags and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_we_r    <= 1'b0;
            wb_addr_r  <= 4'd0;
            wb_data_r  <= 32'd0;
            nzcv_r     <= RESET_NZCV;
            exec_cnt_r <= {CNT_W{1'b0}};
            skip_cnt_r <= {CNT_W{1'b0}};
        end else if (retire_s) begin
            wb_data_r <= F;
            wb_addr_r <= rd_r;
            wb_we_r   <= cond_pass_s & ~is_compare(alu_op_r);
            if (cond_pass_s & (s_r | is_compare(alu_op_r))) begin
                nzcv_r <= NZCV;
            end
            if (cond_pass_s) begin
                if (exec_cnt_r != CNT_MAX) begin
                    exec_cnt_r <= exec_cnt_r + CNT_ONE;
                end
            end else begin
                if (skip_cnt_r != CNT_MAX) begin
                    skip_cnt_r <= skip_cnt_r + CNT_ONE;
                end
            end
        end
    end

    assign in_ready   = in_ready_r;
    assign wb_valid   = wb_valid_r;
    assign wb_we      = wb_we_r;
    assign wb_addr    = wb_addr_r;
    assign wb_data    = wb_data_r;
    assign nzcv_q     = nzcv_r;
    assign exec_cnt   = exec_cnt_r;
    assign skip_cnt   = skip_cnt_r;
    assign A          = a_r;
    assign Shift_Data = shift_data_r;
    assign Shift_Num  = shift_num_r;
    assign SHFT_OP    = shft_op_r;
    assign ALU_OP     = alu_op_r;
    assign CF         = nzcv_r[1];
    assign VF         = nzcv_r[0];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl; a small unshifted ALU model plays the datapath.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_cond, in_alu_op, in_shft_op, in_rd;
    logic        in_s;
    logic [31:0] in_a, in_shift_data, in_shift_num;
    logic [31:0] A, Shift_Data, Shift_Num;
    logic [3:0]  SHFT_OP, ALU_OP;
    logic        CF, VF;
    logic [31:0] F;
    logic [3:0]  NZCV;
    logic        wb_valid, wb_we;
    logic [3:0]  wb_addr, nzcv_q;
    logic [31:0] wb_data;
    logic [15:0] exec_cnt, skip_cnt;

    int total = 0;
    int bad   = 0;

    alu_issue_ctrl #(.RESET_NZCV(4'b0000), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_cond(in_cond), .in_alu_op(in_alu_op), .in_s(in_s),
        .in_shft_op(in_shft_op), .in_a(in_a), .in_shift_data(in_shift_data),
        .in_shift_num(in_shift_num), .in_rd(in_rd),
        .A(A), .Shift_Data(Shift_Data), .Shift_Num(Shift_Num),
        .SHFT_OP(SHFT_OP), .ALU_OP(ALU_OP), .CF(CF), .VF(VF),
        .F(F), .NZCV(NZCV),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .nzcv_q(nzcv_q), .exec_cnt(exec_cnt), .skip_cnt(skip_cnt)
    );

    always #5 clk = ~clk;

    // Datapath stand-in: ALU on A and Shift_Data (shift amount is always 0 here).
    always_comb begin
        logic [32:0] sum;
        logic [31:0] x, y;
        logic        cin, arith, c, v;
        x = A; y = Shift_Data; cin = 1'b0; arith = 1'b1;
        F = 32'd0;
        case (ALU_OP)
            4'b0010, 4'b1010: begin y = ~Shift_Data; cin = 1'b1; end
            4'b0011:          begin x = Shift_Data; y = ~A; cin = 1'b1; end
            4'b0101:          cin = CF;
            4'b0110:          begin y = ~Shift_Data; cin = CF; end
            4'b0111:          begin x = Shift_Data; y = ~A; cin = CF; end
            4'b0100, 4'b1011: cin = 1'b0;
            default:          arith = 1'b0;
        endcase
        sum = {1'b0, x} + {1'b0, y} + {32'd0, cin};
        c = CF; v = VF;
        if (arith) begin
            F = sum[31:0];
            c = sum[32];
            v = (x[31] == y[31]) && (sum[31] != x[31]);
        end else begin
            case (ALU_OP)
                4'b0000, 4'b1000: F = A & Shift_Data;
                4'b0001, 4'b1001: F = A ^ Shift_Data;
                4'b1100:          F = A | Shift_Data;
                4'b1101:          F = Shift_Data;
                4'b1110:          F = A & ~Shift_Data;
                default:          F = ~Shift_Data;
            endcase
        end
        NZCV = {F[31], (F == 32'd0), c, v};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full issue: accept, EXEC, WB, back to IDLE, checked at each negedge.
    task automatic issue(input string tag, input logic [3:0] cond, input logic [3:0] op,
                         input logic s, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] rd, input logic exp_we, input logic [31:0] exp_data,
                         input logic [3:0] exp_nzcv, input logic exp_cf);
        check({tag, "_ready_idle"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; in_cond = cond; in_alu_op = op; in_s = s;
        in_a = a; in_shift_data = d; in_shift_num = 32'd0; in_shft_op = 4'b0110; in_rd = rd;
        @(negedge clk);
        in_valid = 1'b0; in_a = 32'hDEAD_BEEF;
        check({tag, "_ready_exec"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_wbv_exec"}, {31'd0, wb_valid}, 32'd0);
        check({tag, "_cf_exec"}, {31'd0, CF}, {31'd0, exp_cf});
        check({tag, "_drive_a"}, A, a);
        check({tag, "_shft_op"}, {28'd0, SHFT_OP}, 32'd6);
        @(negedge clk);
        check({tag, "_wbv"}, {31'd0, wb_valid}, 32'd1);
        check({tag, "_ready_wb"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_we"}, {31'd0, wb_we}, {31'd0, exp_we});
        check({tag, "_addr"}, {28'd0, wb_addr}, {28'd0, rd});
        check({tag, "_data"}, wb_data, exp_data);
        check({tag, "_nzcv"}, {28'd0, nzcv_q}, {28'd0, exp_nzcv});
        @(negedge clk);
        check({tag, "_wbv_off"}, {31'd0, wb_valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_cond = 4'd0; in_alu_op = 4'd0; in_s = 1'b0;
        in_shft_op = 4'd0; in_a = 32'd0; in_shift_data = 32'd0; in_shift_num = 32'd0; in_rd = 4'd0;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_wbv", {31'd0, wb_valid}, 32'd0);
        check("rst_nzcv", {28'd0, nzcv_q}, 32'd0);
        check("rst_exec", {16'd0, exec_cnt}, 32'd0);
        check("rst_a", A, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        issue("adds",  4'b1110, 4'b0100, 1'b1, 32'd5, 32'd3, 4'd1, 1'b1, 32'd8, 4'b0000, 1'b0);
        check("adds_exec_cnt", {16'd0, exec_cnt}, 32'd1);
        issue("subs",  4'b1110, 4'b0010, 1'b1, 32'd3, 32'd5, 4'd2, 1'b1, 32'hFFFF_FFFE, 4'b1000, 1'b0);
        issue("adc",   4'b1110, 4'b0101, 1'b0, 32'd1, 32'd1, 4'd3, 1'b1, 32'd2, 4'b1000, 1'b0);
        issue("cmp",   4'b1110, 4'b1010, 1'b0, 32'd7, 32'd7, 4'd4, 1'b0, 32'd0, 4'b0110, 1'b0);
        issue("subeq", 4'b0000, 4'b0010, 1'b0, 32'd10, 32'd4, 4'd5, 1'b1, 32'd6, 4'b0110, 1'b1);
        issue("subne", 4'b0001, 4'b0010, 1'b0, 32'd10, 32'd4, 4'd6, 1'b0, 32'd6, 4'b0110, 1'b1);
        check("subne_skip_cnt", {16'd0, skip_cnt}, 32'd1);
        issue("addnv", 4'b1111, 4'b0100, 1'b0, 32'd1, 32'd2, 4'd7, 1'b0, 32'd3, 4'b0110, 1'b1);
        issue("addal", 4'b1110, 4'b0100, 1'b0, 32'h8000_0000, 32'd1, 4'd8, 1'b1, 32'h8000_0001, 4'b0110, 1'b1);
        check("cnt_exec", {16'd0, exec_cnt}, 32'd6);
        check("cnt_skip", {16'd0, skip_cnt}, 32'd2);

        // Continuous in_valid: accept every third edge, one retire per accept.
        in_valid = 1'b1; in_cond = 4'b1110; in_alu_op = 4'b0100; in_s = 1'b0;
        in_a = 32'd1; in_shift_data = 32'd1;
        for (int i = 0; i < 9; i++) begin
            check($sformatf("thr_ready_%0d", i), {31'd0, in_ready}, {31'd0, (i % 3) == 0});
            @(negedge clk);
            check($sformatf("thr_wbv_%0d", i), {31'd0, wb_valid}, {31'd0, (i % 3) == 1});
        end
        in_valid = 1'b0;
        check("thr_exec_cnt", {16'd0, exec_cnt}, 32'd9);
        check("thr_nzcv", {28'd0, nzcv_q}, 32'd6);

        // Reset while in EXEC discards the instruction.
        in_valid = 1'b1; in_cond = 4'b1110; in_alu_op = 4'b0100; in_s = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("rexec_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rexec_wbv", {31'd0, wb_valid}, 32'd0);
        check("rexec_ready_after", {31'd0, in_ready}, 32'd1);
        check("rexec_nzcv", {28'd0, nzcv_q}, 32'd0);
        check("rexec_exec", {16'd0, exec_cnt}, 32'd0);
        check("rexec_skip", {16'd0, skip_cnt}, 32'd0);
        @(negedge clk);
        check("rexec_wbv_next", {31'd0, wb_valid}, 32'd0);
        check("rexec_ready_next", {31'd0, in_ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequential driver/consumer for the combinational ALU_barrelShifter datapath.
- Accepts one decoded data-processing instruction via valid/ready and latches its operands.
- Drives A/Shift_Data/Shift_Num/SHFT_OP/ALU_OP/CF/VF, evaluates the ARM condition field against its NZCV register, captures F/NZCV and issues a register write-back.
- Owns the architectural NZCV flags (CPSR low nibble) that feed CF/VF back into the datapath.

Parameters:
RESET_NZCV, 4'b0000, NZCV value loaded on reset
CNT_W, 16, width of the saturating executed/skipped counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  instruction offered
in_ready  out  1  controller can accept
in_cond  in  4  ARM condition code
in_alu_op  in  4  ARM DP opcode (0000 AND … 1111 MVN)
in_s  in  1  S bit, flag-setting
in_shft_op  in  4  shifter op, passed through untouched
in_a  in  32  Rn value
in_shift_data  in  32  Rm/immediate value
in_shift_num  in  32  shift amount
in_rd  in  4  destination register
A  out  32  to datapath
Shift_Data  out  32  to datapath
Shift_Num  out  32  to datapath
SHFT_OP  out  4  to datapath
ALU_OP  out  4  to datapath
CF  out  1  = nzcv_q[1]
VF  out  1  = nzcv_q[0]
F  in  32  datapath result
NZCV  in  4  datapath flags
wb_valid  out  1  one-cycle retire pulse
wb_we  out  1  register write enable, qualified by wb_valid
wb_addr  out  4  destination register
wb_data  out  32  result
nzcv_q  out  4  architectural flags
exec_cnt  out  CNT_W  executed instructions, saturating
skip_cnt  out  CNT_W  condition-failed instructions, saturating

Behaviour:
- Clocking: one clock `clk`. Reset `rst` is synchronous, active-high.
- FSM states: IDLE, EXEC, WB. Reset enters IDLE.
- Reset values:
  - Datapath-drive registers, wb_* and counters = 0.
  - nzcv_q = RESET_NZCV.
  - in_ready = 1.
- IDLE:
  - in_ready = 1.
  - On in_valid, latch all in_* fields into operand registers, then go to EXEC.
- EXEC:
  - in_ready = 0. Datapath outputs are driven from the latched registers, so the combinational result settles within this cycle.
  - cond_pass is evaluated from the current nzcv_q:
    - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V
    - HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V)
    - AL 1, 1111 treated as never (0).
  - On the clock edge leaving EXEC:
    - wb_data<=F and wb_addr<=rd.
    - wb_we<=cond_pass & !(op in 1000..1011).
    - If cond_pass & (s | op in 1000..1011), nzcv_q<=NZCV.
    - If cond_pass, exec_cnt++; otherwise skip_cnt++.
    - Next state is WB.
- WB:
  - wb_valid = 1 for exactly this cycle; in_ready = 0.
  - Return to IDLE.
- Timing: latency from accept edge to wb_valid is 2 cycles. Peak throughput is one instruction per 3 cycles.
- wb_we, wb_data and wb_addr hold their values after WB but are meaningful only with wb_valid.
- Datapath outputs hold the last latched operands while IDLE.
- A failed condition leaves flags and register file untouched but still produces a retire pulse with wb_we=0.
- TST/TEQ/CMP/CMN always update flags on cond_pass, regardless of in_s.
- Counters saturate at all-ones and never wrap.
- rst in any state: the instruction is discarded, no wb_valid pulse, nzcv_q returns to RESET_NZCV, and the FSM enters IDLE on the next edge.
- in_valid is ignored in EXEC and WB. The upstream must hold the instruction until in_valid & in_ready.

Test Plan:
- Reset, then ADDS (op 0100, s=1, cond 1110) with A=5, data=3, shift 0. Expect wb_valid 2 cycles after accept, wb_data=8, wb_we=1, nzcv_q=0000, exec_cnt=1.
- SUBS A=3, data=5. Expect wb_data=0xFFFFFFFE and nzcv_q=1000 (N=1, C=0 borrow). Next ADC must see CF=0 on the datapath port.
- CMP A=7, data=7. Expect wb_we=0 and nzcv_q=0110. Then SUB cond EQ executes (wb_we=1). Then SUB cond NE is skipped: wb_valid=1, wb_we=0, nzcv_q unchanged, skip_cnt=1.
- ADD without S, cond 1111. Expect skipped, wb_we=0, flags unchanged. Then ADD without S, cond AL, result with N=1. Expect wb_we=1 and nzcv_q unchanged.
- in_valid held high continuously. Expect accepts exactly every 3 cycles, in_ready low in EXEC/WB, no lost or duplicated wb_valid pulses.
- Assert rst during EXEC. Expect no wb_valid, nzcv_q=RESET_NZCV, in_ready=1 the next cycle, counters 0.
